// File: rtl/muldiv_sched.sv
// Issue scheduler for the shared multi-cycle mul/div port: round-robin select
// from the CIQ, fixed-latency sequencing, early wake-up and completion broadcast.
module muldiv_sched #(
    parameter int CIQ_DEPTH = 16,
    parameter int PRF_WIDTH = 6,
    parameter int MUL_LAT   = 4,
    parameter int DIV_LAT   = 32,
    parameter int WAKE_LEAD = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [CIQ_DEPTH-1:0]           req_vec,
    input  logic [CIQ_DEPTH-1:0]           req_is_div,
    input  logic [CIQ_DEPTH*PRF_WIDTH-1:0] ciq_prd,
    input  logic [CIQ_DEPTH-1:0]           ciq_prd_v,
    input  logic                           flush,
    output logic [CIQ_DEPTH-1:0]           grant,
    output logic                           busy,
    output logic                           wake_v,
    output logic [PRF_WIDTH-1:0]           wake_prd,
    output logic                           done_v,
    output logic [PRF_WIDTH-1:0]           done_prd,
    output logic                           done_is_div
);

    localparam int PW     = $clog2(CIQ_DEPTH);
    localparam int MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW0    = $clog2(MAXLAT);
    localparam int CW     = (CW0 < 5) ? 5 : CW0;

    localparam logic [CW-1:0] MUL_INIT = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_INIT = CW'(DIV_LAT - 1);
    localparam logic [CW-1:0] WAKE_CNT = CW'(WAKE_LEAD);

    typedef enum logic {S_IDLE, S_EXEC} state_t;

    state_t               r_st;
    logic [CW-1:0]        r_cnt;
    logic [PW-1:0]        r_ptr;
    logic [PRF_WIDTH-1:0] r_cur_prd;
    logic                 r_cur_prd_v;
    logic                 r_cur_div;

    logic                 w_exec;
    logic                 w_accept;
    logic                 w_grant_any;
    logic [PW-1:0]        w_grant_idx;
    logic [PW-1:0]        w_idx;

    assign w_exec = (r_st == S_EXEC);
    // rst_n gates acceptance so grant stays quiet while reset is held
    assign w_accept = rst_n && !flush && (!w_exec || (r_cnt == '0));

    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_idx       = '0;
        grant       = '0;
        if (w_accept) begin
            for (int i = 0; i < CIQ_DEPTH; i++) begin
                w_idx = r_ptr + PW'(i);
                if (!w_grant_any && req_vec[w_idx]) begin
                    w_grant_any = 1'b1;
                    w_grant_idx = w_idx;
                end
            end
        end
        grant[w_grant_idx] = w_grant_any;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st        <= S_IDLE;
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_cur_prd   <= '0;
            r_cur_prd_v <= 1'b0;
            r_cur_div   <= 1'b0;
        end else if (flush) begin
            r_st  <= S_IDLE;
            r_cnt <= '0;
        end else if (w_grant_any) begin
            r_st        <= S_EXEC;
            r_cnt       <= req_is_div[w_grant_idx] ? DIV_INIT : MUL_INIT;
            r_ptr       <= w_grant_idx + PW'(1);
            r_cur_prd   <= ciq_prd[w_grant_idx*PRF_WIDTH +: PRF_WIDTH];
            r_cur_prd_v <= ciq_prd_v[w_grant_idx];
            r_cur_div   <= req_is_div[w_grant_idx];
        end else if (w_exec) begin
            if (r_cnt == '0) begin
                r_st <= S_IDLE;
            end else begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    // Idle outputs are forced to tag 0, which is always ready
    assign busy        = w_exec && (r_cnt != '0);
    assign done_v      = w_exec && (r_cnt == '0) && !flush;
    assign wake_v      = w_exec && (r_cnt == WAKE_CNT) && r_cur_prd_v && !flush;
    assign wake_prd    = wake_v ? r_cur_prd : '0;
    assign done_prd    = done_v ? r_cur_prd : '0;
    assign done_is_div = done_v && r_cur_div;

endmodule

// File: tb/tb_muldiv_sched.sv
// Bench for muldiv_sched: time-stamped op model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_muldiv_sched;

    localparam int N  = 16;
    localparam int PW = 6;
    localparam int ML = 4;
    localparam int DL = 32;
    localparam int WL = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_vec = '0;
    logic [N-1:0]    req_is_div = '0;
    logic [N*PW-1:0] ciq_prd = '0;
    logic [N-1:0]    ciq_prd_v = '1;
    logic            flush = 1'b0;
    logic [N-1:0]    grant;
    logic            busy;
    logic            wake_v;
    logic [PW-1:0]   wake_prd;
    logic            done_v;
    logic [PW-1:0]   done_prd;
    logic            done_is_div;

    int checks = 0;
    int failures = 0;

    muldiv_sched #(
        .CIQ_DEPTH(N), .PRF_WIDTH(PW), .MUL_LAT(ML), .DIV_LAT(DL), .WAKE_LEAD(WL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_vec(req_vec), .req_is_div(req_is_div),
        .ciq_prd(ciq_prd), .ciq_prd_v(ciq_prd_v), .flush(flush),
        .grant(grant), .busy(busy), .wake_v(wake_v), .wake_prd(wake_prd),
        .done_v(done_v), .done_prd(done_prd), .done_is_div(done_is_div)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_prd(input int i, input int v);
        ciq_prd[i*PW +: PW] = v[PW-1:0];
    endtask

    // Model: one op in flight, described by its issue cycle and latency
    int            cyc_n = 0;
    bit            m_valid = 0;
    int            m_start = 0;
    int            m_lat = 0;
    logic [PW-1:0] m_prd = '0;
    bit            m_prdv = 0;
    bit            m_div = 0;
    int            m_ptr = 0;

    always @(negedge clk) begin
        int           rem;
        int           k;
        bit           avail;
        bit           e_busy, e_done, e_wake;
        logic [N-1:0] eg;
        if (!rst_n) begin
            chk("m_rst_grant", grant, 0);
            chk("m_rst_busy", busy, 0);
            chk("m_rst_wake", wake_v, 0);
            chk("m_rst_done", done_v, 0);
            chk("m_rst_dprd", done_prd, 0);
            m_valid = 0;
            m_ptr   = 0;
        end else begin
            rem   = m_valid ? (m_start + m_lat - cyc_n) : -1;
            avail = !flush && (!m_valid || rem == 0);
            k = -1;
            if (avail)
                for (int j = 0; j < N; j++)
                    if (k < 0 && req_vec[(m_ptr + j) % N]) k = (m_ptr + j) % N;
            eg = '0;
            if (k >= 0) eg[k] = 1'b1;
            e_busy = m_valid && rem > 0;
            e_done = m_valid && rem == 0 && !flush;
            e_wake = m_valid && rem == WL && m_prdv && !flush;
            chk("m_grant", grant, eg);
            chk("m_busy", busy, e_busy);
            chk("m_wake_v", wake_v, e_wake);
            chk("m_wake_prd", wake_prd, e_wake ? m_prd : 0);
            chk("m_done_v", done_v, e_done);
            chk("m_done_prd", done_prd, e_done ? m_prd : 0);
            if (e_done) chk("m_done_div", done_is_div, m_div);
            if (flush) begin
                m_valid = 0;
            end else if (k >= 0) begin
                m_valid = 1;
                m_start = cyc_n;
                m_lat   = req_is_div[k] ? DL : ML;
                m_prd   = ciq_prd[k*PW +: PW];
                m_prdv  = ciq_prd_v[k];
                m_div   = req_is_div[k];
                m_ptr   = (k + 1) % N;
            end else if (m_valid && rem == 0) begin
                m_valid = 0;
            end
        end
        cyc_n++;
    end

    initial begin
        logic [N-1:0] e;
        for (int i = 0; i < N; i++) set_prd(i, i + 1);
        set_prd(4, 9);
        set_prd(0, 17);
        set_prd(6, 0);
        ciq_prd_v[6] = 1'b0;

        #3;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wake_prd", wake_prd, 0);
        chk("rst_done_is_div", done_is_div, 0);
        tick(); tick(); rst_n = 1'b1;

        // single multiply on entry 4, tag 9
        tick(); req_vec = 16'h0010; #2 chk("t1_grant", grant, 16'h0010);
        tick(); req_vec = '0; #2 chk("t1_busy1", busy, 1);
        tick(); #2 chk("t1_wake_v", wake_v, 1); chk("t1_wake_prd", wake_prd, 9);
        tick(); #2 chk("t1_busy3", busy, 1); chk("t1_wake3", wake_v, 0);
        tick(); #2 chk("t1_done_v", done_v, 1); chk("t1_done_prd", done_prd, 9);
        chk("t1_done_div", done_is_div, 0); chk("t1_busy4", busy, 0);
        tick(); #2 chk("t1_done5", done_v, 0);

        // divide on entry 0 blocks entry 3 until its completion cycle
        tick(); req_vec = 16'h0001; req_is_div[0] = 1'b1; #2 chk("t2_grant", grant, 16'h0001);
        tick(); req_vec = '0;
        repeat (4) tick();
        req_vec = 16'h0008; #2 chk("t2_blocked5", grant, 0);
        repeat (25) tick();
        #2 chk("t2_wake_v", wake_v, 1); chk("t2_wake_prd", wake_prd, 17);
        tick(); #2 chk("t2_blocked31", grant, 0);
        tick(); #2 chk("t2_done_v", done_v, 1); chk("t2_done_prd", done_prd, 17);
        chk("t2_done_div", done_is_div, 1); chk("t2_b2b_grant", grant, 16'h0008);
        tick(); req_vec = '0; req_is_div[0] = 1'b0;
        repeat (5) tick();

        // round-robin over a full request vector, ptr starting at 0
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        tick(); req_vec = '1;
        for (int j = 0; j <= 16; j++) begin
            e = 16'h0001 << (j % 16);
            #2 chk("t3_rr_grant", grant, e);
            if (j < 16) repeat (4) tick();
        end
        tick(); req_vec = '0;
        repeat (4) tick();

        // wrap scan: ptr=14 after granting entry 13
        req_vec = 16'h2000; #2 chk("t4_grant13", grant, 16'h2000);
        tick(); req_vec = '0; repeat (4) tick();
        req_vec = 16'h0003; #2 chk("t4_wrap", grant, 16'h0001);
        tick(); req_vec = '0; repeat (4) tick();
        req_vec = 16'h0003; #2 chk("t4_ptr1", grant, 16'h0002);
        tick(); req_vec = '0; repeat (4) tick();

        // flush in the wake cycle
        req_vec = 16'h0010; #2 chk("t5_grant", grant, 16'h0010);
        tick(); req_vec = '0;
        tick(); flush = 1'b1; req_vec = 16'h0020;
        #2 chk("t5_flush_wake", wake_v, 0); chk("t5_flush_grant", grant, 0);
        tick(); flush = 1'b0; #2 chk("t5_regrant", grant, 16'h0020);
        tick(); req_vec = '0; #2 chk("t5_no_done", done_v, 0);
        repeat (4) tick();

        // multiply without a destination register
        req_vec = 16'h0040; #2 chk("t6_grant", grant, 16'h0040);
        tick(); req_vec = '0;
        tick(); #2 chk("t6_wake_v", wake_v, 0); chk("t6_wake_prd", wake_prd, 0);
        tick(); tick(); #2 chk("t6_done_v", done_v, 1); chk("t6_done_prd", done_prd, 0);
        tick();

        // reset in the middle of a divide
        req_vec = 16'h0001; req_is_div[0] = 1'b1; #2 chk("t7_grant", grant, 16'h0001);
        tick(); req_vec = '0;
        repeat (9) tick();
        req_vec = 16'h0003; #1 rst_n = 1'b0; #1;
        chk("t7_rst_busy", busy, 0); chk("t7_rst_grant", grant, 0);
        chk("t7_rst_wake", wake_v, 0); chk("t7_rst_done", done_v, 0);
        tick(); tick(); rst_n = 1'b1; req_is_div[0] = 1'b0;
        #2 chk("t7_ptr0", grant, 16'h0001);
        tick(); req_vec = '0;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
